// File: rtl/regbank_mp.sv
// regbank_mp: WIDTH x DEPTH register bank for the calculator datapath.
// Two registered read ports with read-after-write bypass, one write port with
// load/add/sub/clear modes, an out-of-range write error pulse, and a dump
// sequencer that streams every register in address order over valid/ready.
module regbank_mp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       wmode,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             ovf,
  output logic             werr,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data
);

  // Highest legal address; "addr <= LAST_C" is the in-range test everywhere.
  localparam logic [AW-1:0] LAST_C = AW'(DEPTH - 1);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_ADD   = 2'b01;
  localparam logic [1:0] MODE_SUB   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [0:0]       state_r;

  logic             w_hit_s;
  logic             w_oor_s;
  logic [WIDTH-1:0] w_cur_s;
  logic [WIDTH:0]   w_sum_s;
  logic [WIDTH:0]   w_diff_s;
  logic [WIDTH-1:0] w_val_s;
  logic             w_arith_s;
  logic             w_flag_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;
  logic             beat_s;

  // Write datapath: new register value plus carry/borrow for add/sub.
  always_comb begin
    w_hit_s   = we && (waddr <= LAST_C);
    w_oor_s   = we && (waddr > LAST_C);
    w_cur_s   = '0;
    if (w_hit_s) begin
      w_cur_s = mem_r[waddr];
    end else begin
      w_cur_s = '0;
    end
    // One extra MSB holds the carry out of the add and the borrow of the sub.
    w_sum_s   = {1'b0, w_cur_s} + {1'b0, wdata};
    w_diff_s  = {1'b0, w_cur_s} - {1'b0, wdata};
    w_val_s   = w_cur_s;
    w_arith_s = 1'b0;
    w_flag_s  = 1'b0;
    case (wmode)
      MODE_LOAD: begin
        w_val_s = wdata;
      end
      MODE_ADD: begin
        w_val_s   = w_sum_s[WIDTH-1:0];
        w_arith_s = 1'b1;
        w_flag_s  = w_sum_s[WIDTH];
      end
      MODE_SUB: begin
        w_val_s   = w_diff_s[WIDTH-1:0];
        w_arith_s = 1'b1;
        w_flag_s  = w_diff_s[WIDTH];
      end
      MODE_CLEAR: begin
        w_val_s = '0;
      end
      default: begin
        w_val_s = w_cur_s;
      end
    endcase
  end

  // Read muxes: out-of-range reads give 0, a same-cycle write is forwarded.
  always_comb begin
    rd_a_s = '0;
    rd_b_s = '0;
    if (raddr_a > LAST_C) begin
      rd_a_s = '0;
    end else if (w_hit_s && (raddr_a == waddr)) begin
      rd_a_s = w_val_s;
    end else begin
      rd_a_s = mem_r[raddr_a];
    end
    if (raddr_b > LAST_C) begin
      rd_b_s = '0;
    end else if (w_hit_s && (raddr_b == waddr)) begin
      rd_b_s = w_val_s;
    end else begin
      rd_b_s = mem_r[raddr_b];
    end
  end

  // Register array, read data, overflow flag and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rdata_a <= '0;
      rdata_b <= '0;
      ovf     <= 1'b0;
      werr    <= 1'b0;
    end else begin
      if (w_hit_s) begin
        mem_r[waddr] <= w_val_s;
      end
      // Only an accepted add/sub touches ovf; load/clear leave it alone.
      if (w_hit_s && w_arith_s) begin
        ovf <= w_flag_s;
      end
      werr    <= w_oor_s;
      rdata_a <= rd_a_s;
      rdata_b <= rd_b_s;
    end
  end

  assign beat_s = dump_valid && dump_ready;

  // Dump sequencer: walk addresses 0..DEPTH-1, advancing on each accepted beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      dump_addr <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dump_start) begin
            state_r   <= ST_SCAN;
            dump_addr <= '0;
          end
        end
        ST_SCAN: begin
          if (beat_s && (dump_addr == LAST_C)) begin
            state_r   <= ST_IDLE;
            dump_addr <= '0;
          end else if (beat_s) begin
            dump_addr <= dump_addr + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          dump_addr <= '0;
        end
      endcase
    end
  end

  assign dump_busy  = (state_r == ST_SCAN);
  assign dump_valid = (state_r == ST_SCAN);
  // Live view of the addressed register, so a write during a stall shows up.
  assign dump_data  = mem_r[dump_addr];

endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: randomized + directed bench for regbank_mp. A behavioural
// model predicts every post-edge output; predictions go into queues tagged
// with the cycle they are due, and a negedge monitor pops and compares.
module tb_regbank_mp;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] wmode;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [3:0] raddr_a;
  logic [3:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       ovf;
  logic       werr;
  logic       dump_start;
  logic       dump_busy;
  logic       dump_valid;
  logic       dump_ready;
  logic [3:0] dump_addr;
  logic [7:0] dump_data;

  regbank_mp #(.WIDTH(8), .DEPTH(10), .AW(4)) dut (
    .clk(clk), .reset(reset), .we(we), .wmode(wmode), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .ovf(ovf), .werr(werr),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int due;
    int ra, rb, ovf, werr, dv, da, dd;
  } exp_t;

  typedef struct {
    int    due;
    int    fld;
    int    val;
    string name;
  } cexp_t;

  exp_t  eq[$];
  cexp_t cq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain integers, bank contents and dump progress.
  int m_mem [10];
  int m_ovf, m_werr, m_ra, m_rb, m_idx;
  bit m_act;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask

  // Monitor: compare everything due this cycle on the falling edge.
  exp_t  me;
  cexp_t mc;
  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].due <= cyc) begin
      me = eq.pop_front();
      if (me.due < cyc) begin
        chk("stale_model_entry", 32'(me.due), 32'(cyc));
      end else begin
        chk("rdata_a", {24'd0, rdata_a}, me.ra);
        chk("rdata_b", {24'd0, rdata_b}, me.rb);
        chk("ovf", {31'd0, ovf}, me.ovf);
        chk("werr", {31'd0, werr}, me.werr);
        chk("dump_valid", {31'd0, dump_valid}, me.dv);
        chk("dump_busy", {31'd0, dump_busy}, me.dv);
        chk("dump_addr", {28'd0, dump_addr}, me.da);
        if (me.dv != 0) chk("dump_data", {24'd0, dump_data}, me.dd);
      end
    end
    while (cq.size() > 0 && cq[0].due <= cyc) begin
      mc = cq.pop_front();
      case (mc.fld)
        0: chk(mc.name, {24'd0, rdata_a}, mc.val);
        1: chk(mc.name, {24'd0, rdata_b}, mc.val);
        2: chk(mc.name, {31'd0, ovf}, mc.val);
        3: chk(mc.name, {31'd0, werr}, mc.val);
        4: chk(mc.name, {31'd0, dump_valid}, mc.val);
        5: chk(mc.name, {28'd0, dump_addr}, mc.val);
        6: chk(mc.name, {24'd0, dump_data}, mc.val);
        default: chk(mc.name, {31'd0, dump_busy}, mc.val);
      endcase
    end
  end

  // Directed expectation for the outputs seen after the next step's edge.
  task automatic expc(input int f, input int v, input string n);
    cexp_t c;
    c.due = cyc + 1; c.fld = f; c.val = v; c.name = n;
    cq.push_back(c);
  endtask

  // Drive one cycle of inputs, advance the model, queue its prediction.
  task automatic step(input bit rst, input bit w, input int md, input int wa,
                      input int wd, input int a, input int b,
                      input bit ds, input bit dr);
    exp_t x;
    int   t;
    reset = rst; we = w; wmode = md[1:0]; waddr = wa[3:0]; wdata = wd[7:0];
    raddr_a = a[3:0]; raddr_b = b[3:0]; dump_start = ds; dump_ready = dr;
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_ovf = 0; m_werr = 0; m_ra = 0; m_rb = 0; m_act = 1'b0; m_idx = 0;
    end else begin
      m_werr = (w && wa >= 10) ? 1 : 0;
      if (w && wa < 10) begin
        case (md)
          0: m_mem[wa] = wd;
          1: begin
            t = m_mem[wa] + wd;
            m_ovf = (t > 255) ? 1 : 0;
            m_mem[wa] = t % 256;
          end
          2: begin
            m_ovf = (wd > m_mem[wa]) ? 1 : 0;
            m_mem[wa] = (m_mem[wa] - wd + 256) % 256;
          end
          default: m_mem[wa] = 0;
        endcase
      end
      m_ra = (a < 10) ? m_mem[a] : 0;
      m_rb = (b < 10) ? m_mem[b] : 0;
      if (m_act) begin
        if (dr) begin
          if (m_idx == 9) begin
            m_act = 1'b0; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (ds) begin
        m_act = 1'b1; m_idx = 0;
      end
    end
    x.due = cyc + 1; x.ra = m_ra; x.rb = m_rb; x.ovf = m_ovf; x.werr = m_werr;
    x.dv = m_act ? 1 : 0; x.da = m_idx; x.dd = m_act ? m_mem[m_idx] : 0;
    eq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int a, input int b);
    step(1'b1, 1'b0, 0, 0, 0, a, b, 1'b0, 1'b1);
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    // Let any dump the random traffic started run to completion.
    for (int k = 0; k < 12 && m_act; k++) idle(0, 0);
  endtask

  initial begin
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // 1: random traffic, then two reset cycles clear everything.
    random_cycles(40);
    expc(2, 0, "reset_ovf");
    expc(3, 0, "reset_werr");
    expc(4, 0, "reset_dump_valid");
    step(1'b0, 1'b1, 0, 2, 8'h55, 2, 2, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      expc(0, 0, "reset_rdata_a");
      expc(1, 0, "reset_rdata_b");
      idle(i, 9 - i);
    end

    // 2: load/add/load/sub on R3 with ovf behaviour.
    step(1'b1, 1'b1, 0, 3, 8'h7F, 3, 3, 1'b0, 1'b1);
    expc(0, 8'h0F, "add_result");
    expc(2, 1, "add_carry");
    step(1'b1, 1'b1, 1, 3, 8'h90, 3, 3, 1'b0, 1'b1);
    expc(0, 8'h01, "load_after_add");
    expc(2, 1, "load_keeps_ovf");
    step(1'b1, 1'b1, 0, 3, 8'h01, 3, 3, 1'b0, 1'b1);
    expc(0, 8'hFF, "sub_result");
    expc(2, 1, "sub_borrow");
    step(1'b1, 1'b1, 2, 3, 8'h02, 3, 3, 1'b0, 1'b1);
    expc(2, 0, "add_no_carry");
    step(1'b1, 1'b1, 1, 7, 8'h01, 7, 7, 1'b0, 1'b1);

    // 3: same-cycle bypass on both ports.
    expc(0, 8'hA5, "bypass_a");
    expc(1, 8'hA5, "bypass_b");
    step(1'b1, 1'b1, 0, 5, 8'hA5, 5, 5, 1'b0, 1'b1);

    // 4: out-of-range write pulses werr for exactly one cycle.
    expc(3, 1, "werr_pulse");
    expc(0, 0, "oor_read");
    step(1'b1, 1'b1, 0, 12, 8'h33, 12, 5, 1'b0, 1'b1);
    expc(3, 0, "werr_clears");
    idle(3, 5);
    for (int i = 0; i < 10; i++) idle(i, 9 - i);

    // 5: full dump at ready=1.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 0, i, 8'h10 + i, i, i, 1'b0, 1'b1);
    expc(5, 0, "dump_addr_0");
    expc(6, 8'h10, "dump_data_0");
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k < 9) begin
        expc(5, k + 1, "dump_addr_seq");
        expc(6, 8'h11 + k, "dump_data_seq");
      end else begin
        expc(7, 0, "dump_busy_done");
      end
      idle(k, k);
    end

    // 6: stall at beat 4, write during stall, reset at beat 6.
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) idle(0, 0);
    expc(5, 4, "stall_addr_1");
    step(1'b1, 1'b0, 0, 0, 0, 4, 4, 1'b1, 1'b0);
    expc(5, 4, "stall_addr_2");
    expc(6, 8'h77, "stall_live_data");
    step(1'b1, 1'b1, 0, 4, 8'h77, 4, 4, 1'b0, 1'b0);
    expc(5, 4, "stall_addr_3");
    step(1'b1, 1'b0, 0, 0, 0, 4, 4, 1'b0, 1'b0);
    idle(0, 0);
    expc(5, 6, "beat_6");
    idle(0, 0);
    expc(4, 0, "abort_valid");
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    expc(4, 0, "abort_stays_idle");
    idle(0, 0);

    // Random traffic with dumps interleaved.
    random_cycles(200);

    repeat (2) @(negedge clk);
    chk("model_queue_drained", 32'(eq.size()), 32'd0);
    chk("directed_queue_drained", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
